cp0_except_seq: RTL and testbench
=================================

# cp0_except_seq

Coprocessor-0 register file plus exception-commit sequencer for the M stage. Takes the prioritised exception code from the M-stage exception unit and waits out any memory-side stall. It then commits the exception into Status/Cause/EPC/BadVAddr in one cycle and issues a single-cycle pipeline flush with a redirect PC. It also owns the Count/Compare timer that feeds the timer-interrupt bit back to the exception unit.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `stallM` in 1: M stage is held by the memory side.
- `exc_valid` in 1: the exception unit reports a nonzero except_type.
- `exc_code` in 5: except_type[4:0] (0x01 int, 0x04/0x05 AdEL/AdES, 0x08 sys, 0x09 bp, 0x0a RI, 0x0c Ov, 0x0e eret).
- `exc_pc` in 32: pcM.
- `exc_bd` in 1: the faulting instruction is in a delay slot.
- `exc_badvaddr` in 32: badvaddrM.
- `ext_int` in 6: hardware interrupt lines.
- `mtc0_en` in 1: write strobe for the CP0 register at `mtc0_addr`.
- `mtc0_addr` in 5: CP0 write address.
- `mtc0_data` in 32: CP0 write data.
- `mfc0_addr` in 5: CP0 read address.
- `mfc0_data` out 32: CP0 read data.
- `cp0_status` out 32, `cp0_cause` out 32, `cp0_epc` out 32: live register values, fed to the exception unit.
- `busy` out 1: the sequencer is in HOLD or COMMIT; upstream stages must stall.
- `flush_req` out 1: one-cycle flush of IF..M.
- `redirect_pc` out 32: fetch target, valid while `flush_req` is 1.

## Operation
- CP0 addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other address reads 0 and ignores writes.
- `mfc0_data` is a combinational read.
- Writable fields:
  - Status IM[15:8], EXL[1], IE[0]; all other Status bits are constant (BEV[22]=1).
  - Cause IP[9:8] only.
  - EPC, Count and Compare are fully writable. BadVAddr is read-only.
- Cause IP[15:10] = {ext_int[5] | TI, ext_int[4:0]}, registered every cycle. Cause TI is bit 30.
- Timer:
  - A 1-bit `tick` toggles every cycle; Count increments when `tick`=1.
  - An mtc0 to Count loads the value and clears `tick`.
  - TI is set the cycle after the registered Count equals Compare. It is cleared by any mtc0 to Compare, and clear wins over a same-cycle set.
- State machine:
  - **IDLE**:
    - `exc_valid` & ~`stallM` → COMMIT.
    - `exc_valid` & `stallM` → HOLD.
    - In both cases `exc_code`, `exc_pc`, `exc_bd` and `exc_badvaddr` are latched in the same cycle.
  - **HOLD**: inputs are ignored and the latched values are kept. `stallM`=0 → COMMIT.
  - **COMMIT**: one cycle, then → IDLE. Performs the CP0 update and asserts `flush_req`. `exc_valid` is ignored.
- Commit rules for any code ≠ 0x0e:
  - If EXL=0: EPC = bd ? pc−4 : pc, and Cause.BD[31] = bd. If EXL=1, EPC and BD are unchanged.
  - Status.EXL ← 1.
  - Cause.ExcCode[6:2] ← code, except code 0x01 is written as 0x00.
  - BadVAddr ← latched badvaddr for codes 0x04/0x05 only.
  - `redirect_pc` = 0xBFC0_0380.
- Commit rules for eret (0x0e): Status.EXL ← 0 and `redirect_pc` = EPC. The EPC value used is the one held at the COMMIT cycle.
- An `mtc0_en` asserted while the state is COMMIT is discarded entirely.
- An `mtc0_en` in IDLE/HOLD applies normally, next edge.

## Timing
- Reset values: Status 0x0040_0000, Cause 0, EPC 0, BadVAddr 0, Count 0, Compare 0, `tick` 0, state IDLE, `flush_req` 0, `redirect_pc` 0, `busy` 0.
- Latency with no stall: `exc_valid` sampled at edge N → `flush_req`=1 and CP0 updated during cycle N+1. Updated register values are visible from edge N+2.
- With a stall: `flush_req` rises the cycle after the first edge that samples `stallM`=0 in HOLD.
- `busy` is combinational from state: 1 in HOLD and COMMIT.
- `flush_req`/`redirect_pc` are registered outputs, high for exactly one cycle per exception.
- `redirect_pc` returns to 0 when `flush_req` is 0.
- Back-to-back exceptions: an `exc_valid` during COMMIT is dropped. The next one is accepted from IDLE at the following edge.
- Reset mid-HOLD/COMMIT: immediate return to IDLE and reset values. No flush is emitted.

## Test plan
- Reset, then read all six CP0 addresses → Status 0x0040_0000, all others 0. Read address 3 → 0.
- syscall (0x08) with pc 0xBFC0_1000, bd=0, no stall → `flush_req` high one cycle with `redirect_pc` 0xBFC0_0380. Then EPC 0xBFC0_1000, Cause.ExcCode 8, EXL 1.
- AdEL (0x04) in a delay slot with pc 0xBFC0_2004, badvaddr 0x0000_0003, `stallM` held 3 cycles → `busy` high for 4 cycles, `flush_req` in the 4th. Then EPC 0xBFC0_2000, BD 1, BadVAddr 0x3.
- eret after an exception with EPC 0x8000_0100 → `redirect_pc` 0x8000_0100 and EXL cleared. A second exception taken while EXL=1 leaves EPC unchanged.
- Write Compare 10 and Count 0 → TI sets about 21 cycles later and Cause[15] follows. An mtc0 to Compare clears TI.
- mtc0 Status 0xFFFF_FFFF during a COMMIT cycle → discarded. The same write in IDLE → Status reads 0x0040_FF03.

Source files
------------

// File: rtl/cp0_except_seq.sv
// ============================================================================
// Module   : cp0_except_seq
// Brief    : CP0 register file, Count/Compare timer and M-stage exception
//            commit sequencer (IDLE -> [HOLD] -> COMMIT) with flush/redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_except_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallM,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic [5:0]  ext_int,
    input  logic        mtc0_en,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc,
    output logic        busy,
    output logic        flush_req,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0]  c_ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  c_ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  c_ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  c_ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  c_ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  c_ADDR_EPC      = 5'd14;
    localparam logic [4:0]  c_CODE_INT      = 5'h01;
    localparam logic [4:0]  c_CODE_ADEL     = 5'h04;
    localparam logic [4:0]  c_CODE_ADES     = 5'h05;
    localparam logic [4:0]  c_CODE_ERET     = 5'h0e;
    localparam logic [31:0] c_EXC_VECTOR    = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        w_latch;

    logic [4:0]  r_code;
    logic [31:0] r_pc, r_bva;
    logic        r_bd;

    logic [7:0]  r_im;
    logic        r_exl, r_ie;
    logic        r_cause_bd, r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc, r_badvaddr, r_count, r_compare;
    logic        r_tick;

    logic        r_flush;
    logic [31:0] r_redirect;

    logic        w_commit, w_mtc0, w_exc_commit, w_take_epc, w_enter_commit;
    logic [4:0]  w_code_sel;
    logic [31:0] w_epc_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exc_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = stallM ? ST_HOLD : ST_COMMIT;
                end
            end
            ST_HOLD:   if (!stallM) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Writes landing in the commit cycle are dropped so they cannot race the update.
    assign w_commit       = (r_state == ST_COMMIT);
    assign w_mtc0         = mtc0_en & ~w_commit;
    assign w_exc_commit   = w_commit & (r_code != c_CODE_ERET);
    assign w_take_epc     = w_exc_commit & ~r_exl;
    assign w_enter_commit = (w_state_nxt == ST_COMMIT) & ~w_commit;
    assign w_code_sel     = (r_state == ST_IDLE) ? exc_code : r_code;

    always_comb begin
        w_epc_nxt = r_epc;
        if (w_take_epc)
            w_epc_nxt = r_bd ? (r_pc - 32'd4) : r_pc;
        else if (w_mtc0 && mtc0_addr == c_ADDR_EPC)
            w_epc_nxt = mtc0_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_code <= 5'd0;
            r_pc   <= 32'd0;
            r_bd   <= 1'b0;
            r_bva  <= 32'd0;
        end else if (w_latch) begin
            r_code <= exc_code;
            r_pc   <= exc_pc;
            r_bd   <= exc_bd;
            r_bva  <= exc_badvaddr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_cause_bd <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            r_epc   <= w_epc_nxt;
            r_ip_hw <= {ext_int[5] | r_ti, ext_int[4:0]};
            if (w_commit) begin
                r_exl <= (r_code != c_CODE_ERET);
            end else if (w_mtc0 && mtc0_addr == c_ADDR_STATUS) begin
                r_im  <= mtc0_data[15:8];
                r_exl <= mtc0_data[1];
                r_ie  <= mtc0_data[0];
            end
            if (w_take_epc)
                r_cause_bd <= r_bd;
            if (w_exc_commit)
                r_exccode <= (r_code == c_CODE_INT) ? 5'd0 : r_code;
            if (w_exc_commit && (r_code == c_CODE_ADEL || r_code == c_CODE_ADES))
                r_badvaddr <= r_bva;
            if (w_mtc0 && mtc0_addr == c_ADDR_CAUSE)
                r_ip_sw <= mtc0_data[9:8];
        end
    end

    // Count advances every other cycle; a Compare write clears TI ahead of any match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= 32'd0;
            r_tick    <= 1'b0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            if (w_mtc0 && mtc0_addr == c_ADDR_COUNT) begin
                r_count <= mtc0_data;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick)
                    r_count <= r_count + 32'd1;
            end
            if (w_mtc0 && mtc0_addr == c_ADDR_COMPARE) begin
                r_compare <= mtc0_data;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_flush    <= 1'b0;
            r_redirect <= 32'd0;
        end else begin
            r_flush    <= w_enter_commit;
            r_redirect <= !w_enter_commit ? 32'd0 :
                          (w_code_sel == c_CODE_ERET) ? w_epc_nxt : c_EXC_VECTOR;
        end
    end

    assign cp0_status  = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign cp0_cause   = {r_cause_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'd0};
    assign cp0_epc     = r_epc;
    assign busy        = (r_state != ST_IDLE);
    assign flush_req   = r_flush;
    assign redirect_pc = r_redirect;

    always_comb begin
        mfc0_data = 32'd0;
        case (mfc0_addr)
            c_ADDR_BADVADDR: mfc0_data = r_badvaddr;
            c_ADDR_COUNT:    mfc0_data = r_count;
            c_ADDR_COMPARE:  mfc0_data = r_compare;
            c_ADDR_STATUS:   mfc0_data = cp0_status;
            c_ADDR_CAUSE:    mfc0_data = cp0_cause;
            c_ADDR_EPC:      mfc0_data = r_epc;
            default:         mfc0_data = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_except_seq.sv
// ============================================================================
// Module   : tb_cp0_except_seq
// Brief    : Self-checking bench for cp0_except_seq with a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_except_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallM, exc_valid, exc_bd, mtc0_en;
    logic [4:0]  exc_code, mtc0_addr, mfc0_addr;
    logic [31:0] exc_pc, exc_badvaddr, mtc0_data;
    logic [5:0]  ext_int;
    logic [31:0] mfc0_data, cp0_status, cp0_cause, cp0_epc, redirect_pc;
    logic        busy, flush_req;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural model of the software-visible CP0 state.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [31:0] m_epc, m_bva, m_compare;

    localparam logic [31:0] c_CAUSE_MASK = 32'hBFFF_03FF;

    cp0_except_seq dut (
        .clk(clk), .resetn(resetn), .stallM(stallM), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .ext_int(ext_int), .mtc0_en(mtc0_en),
        .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr),
        .mfc0_data(mfc0_data), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .busy(busy), .flush_req(flush_req),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
    endfunction

    task automatic model_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = 0; m_ipsw = 0;
        m_epc = 0; m_bva = 0; m_compare = 0;
    endtask

    task automatic model_commit(input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic [31:0] bva);
        if (code == 5'h0e) begin
            m_exl = 0;
        end else begin
            if (!m_exl) begin
                m_epc = bd ? pc - 32'd4 : pc;
                m_bd  = bd;
            end
            m_exl = 1;
            m_exc = (code == 5'h01) ? 5'h00 : code;
            if (code == 5'h04 || code == 5'h05) m_bva = bva;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        mfc0_addr = a;
        #1;
        v = mfc0_data;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
        cyc();
        mtc0_en = 0;
        case (a)
            5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
            5'd13: m_ipsw = d[9:8];
            5'd14: m_epc = d;
            5'd11: m_compare = d;
            default: ;
        endcase
    endtask

    // Raises one exception, holds stallM for nstall edges, checks the busy/flush
    // window and the resulting registers against the model.
    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                          input logic bd, input logic [31:0] bva, input int nstall);
        logic [31:0] exp_rd, v;
        exp_rd = (code == 5'h0e) ? m_epc : 32'hBFC0_0380;
        exc_valid = 1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
        stallM = (nstall > 0);
        cyc();
        for (int k = 0; k <= nstall; k++) begin
            exc_valid = 1'($urandom_range(0, 1)); exc_code = 5'($urandom);
            exc_pc = $urandom; exc_bd = 1'($urandom); exc_badvaddr = $urandom;
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL exc_busy k=%0d got %b want 1", k, busy);
            end
            checks++;
            if (flush_req !== (k == nstall)) begin
                errors++; $display("FAIL exc_flush k=%0d got %b want %b", k, flush_req, k == nstall);
            end
            if (k == nstall) begin
                checks++;
                if (redirect_pc !== exp_rd) begin
                    errors++; $display("FAIL exc_redirect got %h want %h", redirect_pc, exp_rd);
                end
            end
            stallM = (k + 1 < nstall);
            cyc();
        end
        exc_valid = 0; stallM = 0;
        checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL exc_after got busy=%b flush=%b rpc=%h want 0/0/0", busy, flush_req, redirect_pc);
        end
        model_commit(code, pc, bd, bva);
        rd(12, v); checks++;
        if (v !== m_status()) begin errors++; $display("FAIL exc_status got %h want %h", v, m_status()); end
        rd(13, v); checks++;
        if ((v & c_CAUSE_MASK) !== m_cause()) begin errors++; $display("FAIL exc_cause got %h want %h", v & c_CAUSE_MASK, m_cause()); end
        rd(14, v); checks++;
        if (v !== m_epc || cp0_epc !== m_epc) begin errors++; $display("FAIL exc_epc got %h want %h", v, m_epc); end
        rd(8, v); checks++;
        if (v !== m_bva) begin errors++; $display("FAIL exc_badvaddr got %h want %h", v, m_bva); end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [4:0]  addrs [7];
        logic [31:0] exps  [7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        exps  = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0};
        resetn = 0; stallM = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
        exc_badvaddr = 0; ext_int = 0; mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0; mfc0_addr = 0;
        model_reset();
        cyc(); cyc();
        checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0 || redirect_pc !== 32'd0) begin
            errors++; $display("FAIL reset_out got busy=%b flush=%b rpc=%h want 0/0/0", busy, flush_req, redirect_pc);
        end
        for (int i = 0; i < 7; i++) begin
            rd(addrs[i], v); checks++;
            if (v !== exps[i]) begin errors++; $display("FAIL reset_read a=%0d got %h want %h", addrs[i], v, exps[i]); end
        end
        resetn = 1;
        cyc();
    endtask

    task automatic test_syscall();
        logic [31:0] v;
        do_exc(5'h08, 32'hBFC0_1000, 1'b0, $urandom, 0);
        rd(14, v); checks++;
        if (v !== 32'hBFC0_1000) begin errors++; $display("FAIL sys_epc got %h want bfc01000", v); end
        rd(13, v); checks++;
        if (v[6:2] !== 5'h08) begin errors++; $display("FAIL sys_exccode got %h want 08", v[6:2]); end
        rd(12, v); checks++;
        if (v[1] !== 1'b1) begin errors++; $display("FAIL sys_exl got %b want 1", v[1]); end
        do_exc(5'h0e, $urandom, 1'b0, $urandom, 0);
    endtask

    task automatic test_adel_stall();
        logic [31:0] v;
        do_exc(5'h04, 32'hBFC0_2004, 1'b1, 32'h0000_0003, 3);
        rd(14, v); checks++;
        if (v !== 32'hBFC0_2000) begin errors++; $display("FAIL adel_epc got %h want bfc02000", v); end
        rd(13, v); checks++;
        if (v[31] !== 1'b1) begin errors++; $display("FAIL adel_bd got %b want 1", v[31]); end
        rd(8, v); checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL adel_badvaddr got %h want 3", v); end
        do_exc(5'h0e, $urandom, 1'b0, $urandom, 1);
    endtask

    task automatic test_eret();
        logic [31:0] v;
        do_exc(5'h0c, 32'h8000_0100, 1'b0, $urandom, 0);
        do_exc(5'h0e, $urandom, 1'b0, $urandom, 2);
        rd(12, v); checks++;
        if (v[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got %b want 0", v[1]); end
        do_exc(5'h08, 32'h8000_2000, 1'b0, $urandom, 0);
        do_exc(5'h0a, 32'h8000_3000, 1'b1, $urandom, 1);
        rd(14, v); checks++;
        if (v !== 32'h8000_2000) begin errors++; $display("FAIL nested_epc got %h want 80002000", v); end
        do_exc(5'h0e, $urandom, 1'b0, $urandom, 0);
    endtask

    task automatic test_commit_mtc0();
        logic [31:0] v;
        exc_valid = 1; exc_code = 5'h09; exc_pc = 32'hBFC0_4000; exc_bd = 0; stallM = 0;
        cyc();
        exc_valid = 0;
        mtc0_en = 1; mtc0_addr = 5'd12; mtc0_data = 32'hFFFF_FFFF;
        checks++;
        if (flush_req !== 1'b1) begin errors++; $display("FAIL cm_flush got %b want 1", flush_req); end
        cyc();
        mtc0_en = 0;
        model_commit(5'h09, 32'hBFC0_4000, 1'b0, 32'd0);
        rd(12, v); checks++;
        if (v !== m_status()) begin errors++; $display("FAIL cm_discard got %h want %h", v, m_status()); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(12, v); checks++;
        if (v !== 32'h0040_FF03 || cp0_status !== 32'h0040_FF03) begin
            errors++; $display("FAIL cm_status got %h want 0040ff03", v);
        end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_timer();
        logic [31:0] c, n;
        logic [5:0]  e;
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        for (int k = 1; k <= 24; k++) begin
            rd(13, c); rd(9, n);
            checks++;
            if (c[30] !== (k >= 21)) begin errors++; $display("FAIL ti k=%0d got %b want %b", k, c[30], k >= 21); end
            checks++;
            if (n !== 32'(k / 2)) begin errors++; $display("FAIL count k=%0d got %0d want %0d", k, n, k / 2); end
            if (k >= 2) begin
                checks++;
                if (c[15] !== (k >= 22)) begin errors++; $display("FAIL ip7 k=%0d got %b want %b", k, c[15], k >= 22); end
            end
            cyc();
        end
        mtc0(5'd11, 32'd1000);
        rd(13, c); checks++;
        if (c[30] !== 1'b0) begin errors++; $display("FAIL ti_clear got %b want 0", c[30]); end
        e = 6'($urandom) | 6'h01;
        ext_int = e;
        cyc();
        rd(13, c); checks++;
        if (c[15:10] !== e) begin errors++; $display("FAIL ext_int got %h want %h", c[15:10], e); end
        ext_int = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        exc_valid = 1; exc_code = 5'h08; exc_pc = 32'h1234_5678; stallM = 1;
        cyc();
        exc_valid = 0;
        #2 resetn = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid got busy=%b flush=%b want 0/0", busy, flush_req);
        end
        model_reset();
        cyc();
        resetn = 1; stallM = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (flush_req !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_noflush got flush=%b busy=%b want 0/0", flush_req, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  codes [8];
        logic [4:0]  addrs [8];
        logic [31:0] v;
        codes = '{5'h01, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h0e};
        addrs = '{5'd3, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd20};
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                mtc0(addrs[$urandom_range(0, 7)], $urandom);
                rd(11, v); checks++;
                if (v !== m_compare) begin errors++; $display("FAIL rnd_compare got %h want %h", v, m_compare); end
                rd(12, v); checks++;
                if (v !== m_status()) begin errors++; $display("FAIL rnd_status got %h want %h", v, m_status()); end
                rd(13, v); checks++;
                if ((v & c_CAUSE_MASK) !== m_cause()) begin errors++; $display("FAIL rnd_cause got %h want %h", v & c_CAUSE_MASK, m_cause()); end
                rd(14, v); checks++;
                if (v !== m_epc) begin errors++; $display("FAIL rnd_epc got %h want %h", v, m_epc); end
                rd(8, v); checks++;
                if (v !== m_bva) begin errors++; $display("FAIL rnd_badvaddr got %h want %h", v, m_bva); end
                rd(3, v); checks++;
                if (v !== 32'd0) begin errors++; $display("FAIL rnd_unmapped got %h want 0", v); end
            end else begin
                do_exc(codes[$urandom_range(0, 7)], $urandom, 1'($urandom), $urandom,
                       int'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_adel_stall();
        test_eret();
        test_commit_mtc0();
        test_timer();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
